// File: rtl/reg_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_access_arbiter_if
// Bundles the requester-side handshake and the shared-register drive pins
// of reg_access_arbiter.
//   master : requester side (drives req/clr_req/req_data/flush, sees ack etc.)
//   slave  : arbiter side
// Signals:
//   req        [NREQ]    per-requester load request (level, held until ack)
//   clr_req    [NREQ]    per-requester clear request (level, held until ack)
//   req_data   [NREQ*N]  per-requester load data, requester i at [i*N +: N]
//   flush                global clear command, beats every requester
//   lock       [NREQ]    priority lock, present only with REG_ARB_LOCK_EN
//   ack        [NREQ]    one-hot, one-cycle pulse to the served requester
//   reg_load / reg_clear strobes to the shared register
//   reg_in     [N]       data to the shared register
//   last_grant [PW]      index of the most recently served requester
//   busy                 high whenever a strobe is high
// ---------------------------------------------------------------------------
interface reg_access_arbiter_if #(
    parameter int N    = 8,
    parameter int NREQ = 4
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   clr_req;
    logic [NREQ*N-1:0] req_data;
    logic              flush;
`ifdef REG_ARB_LOCK_EN
    logic [NREQ-1:0]   lock;
`endif
    logic [NREQ-1:0]   ack;
    logic              reg_load;
    logic              reg_clear;
    logic [N-1:0]      reg_in;
    logic [PW-1:0]     last_grant;
    logic              busy;

    modport master (
        output req, clr_req, req_data, flush,
`ifdef REG_ARB_LOCK_EN
        output lock,
`endif
        input  ack, reg_load, reg_clear, reg_in, last_grant, busy
    );

    modport slave (
        input  req, clr_req, req_data, flush,
`ifdef REG_ARB_LOCK_EN
        input  lock,
`endif
        output ack, reg_load, reg_clear, reg_in, last_grant, busy
    );
endinterface

// File: rtl/reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// reg_access_arbiter
// Round-robin arbiter sharing one N-bit load/clear register among NREQ
// requesters; one transaction per cycle, all outputs registered.
// Ports:
//   clk    rising-edge clock
//   clear  synchronous active-high reset
//   bus    reg_access_arbiter_if.slave (requests, flush, register drive, ack)
// Optional feature: define REG_ARB_LOCK_EN to add bus.lock; a served
// requester with its lock bit set keeps top priority (pointer stays on it).
//
// state | meaning
// IDLE  | nothing asserted, reg_in holds its last value
// SERVE | one ack plus one strobe (load, or clear if clr_req wins)
// FLUSH | reg_clear only, no ack, pointer untouched
// ---------------------------------------------------------------------------
module reg_access_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 clear,
    reg_access_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SERVE, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            load_q, load_d;
    logic            clr_q, clr_d;
    logic [N-1:0]    in_q, in_d;
    logic [PW-1:0]   last_q, last_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] active;
    logic            found;
    logic [PW-1:0]   gidx;
    int              idx;

    always_comb begin
        state_d = IDLE;
        ack_d   = '0;
        load_d  = 1'b0;
        clr_d   = 1'b0;
        in_d    = in_q;
        last_d  = last_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        gidx    = '0;
        idx     = 0;

        // The requester showing ack this cycle is masked so a request it is
        // still dropping cannot be granted twice.
        active = (bus.req | bus.clr_req) & ~ack_q;

        // Scan farthest-to-nearest from ptr; the last hit is the first one in
        // round-robin order. Explicit wrap keeps non-power-of-two NREQ in range.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (active[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end

        if (bus.flush) begin
            state_d = FLUSH;
            clr_d   = 1'b1;
            in_d    = '0;
        end else if (found) begin
            state_d     = SERVE;
            ack_d[gidx] = 1'b1;
            last_d      = gidx;
            if (int'(gidx) == NREQ - 1) ptr_d = '0;
            else                        ptr_d = gidx + PW'(1);
`ifdef REG_ARB_LOCK_EN
            if (bus.lock[gidx]) ptr_d = gidx;
`endif
            if (bus.clr_req[gidx]) begin
                clr_d = 1'b1;
                in_d  = '0;
            end else begin
                load_d = 1'b1;
                in_d   = bus.req_data[int'(gidx)*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            ack_q   <= '0;
            load_q  <= 1'b0;
            clr_q   <= 1'b0;
            in_q    <= '0;
            last_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            clr_q   <= clr_d;
            in_q    <= in_d;
            last_q  <= last_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.reg_load   = load_q;
    assign bus.reg_clear  = clr_q;
    assign bus.reg_in     = in_q;
    assign bus.last_grant = last_q;
    // Every non-IDLE state drives exactly one strobe.
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_reg_access_arbiter.sv
module tb_reg_access_arbiter;
    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int PW   = $clog2(NREQ);

    logic clk;
    logic clear;
    int   checks;
    int   errors;

    reg_access_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    reg_access_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: served-requester bookkeeping by the stated rules.
    // ------------------------------------------------------------------
    logic [NREQ-1:0] m_ack;
    logic            m_load, m_clr, m_valid;
    logic [N-1:0]    m_in;
    int              m_last, m_ptr;

    initial begin
        m_valid = 1'b0;
        m_ack = '0; m_load = 1'b0; m_clr = 1'b0; m_in = '0;
        m_last = 0; m_ptr = 0;
    end

    always @(posedge clk) begin
        int order[$];
        int g;
        if (clear) begin
            m_valid = 1'b1;
            m_ack = '0; m_load = 1'b0; m_clr = 1'b0; m_in = '0;
            m_last = 0; m_ptr = 0;
        end else if (bus.flush) begin
            m_ack = '0; m_load = 1'b0; m_clr = 1'b1; m_in = '0;
        end else begin
            order = {};
            for (int k = 0; k < NREQ; k++) order.push_back((m_ptr + k) % NREQ);
            g = -1;
            foreach (order[j])
                if (g < 0 && (bus.req[order[j]] || bus.clr_req[order[j]]) && !m_ack[order[j]])
                    g = order[j];
            if (g < 0) begin
                m_ack = '0; m_load = 1'b0; m_clr = 1'b0;
            end else begin
                m_ack = '0;
                m_ack[g] = 1'b1;
                m_last = g;
                m_ptr = (g + 1) % NREQ;
                if (bus.clr_req[g]) begin
                    m_clr = 1'b1; m_load = 1'b0; m_in = '0;
                end else begin
                    m_clr = 1'b0; m_load = 1'b1; m_in = bus.req_data[g*N +: N];
                end
            end
        end
        #1;
        if (m_valid) begin
            check("m_ack",   32'(bus.ack),        32'(m_ack));
            check("m_load",  32'(bus.reg_load),   32'(m_load));
            check("m_clear", 32'(bus.reg_clear),  32'(m_clr));
            check("m_in",    32'(bus.reg_in),     32'(m_in));
            check("m_last",  32'(bus.last_grant), 32'(m_last));
            check("m_busy",  32'(bus.busy),       32'(m_load | m_clr));
        end
    end

    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [NREQ-1:0] a, input logic ld,
                              input logic cl, input logic [N-1:0] d, input int lg);
        check({name, ".ack"},   32'(bus.ack),        32'(a));
        check({name, ".load"},  32'(bus.reg_load),   32'(ld));
        check({name, ".clear"}, 32'(bus.reg_clear),  32'(cl));
        check({name, ".in"},    32'(bus.reg_in),     32'(d));
        check({name, ".last"},  32'(bus.last_grant), 32'(lg));
        check({name, ".busy"},  32'(bus.busy),       32'(ld | cl));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        clear = 1'b1;
        bus.req = '0; bus.clr_req = '0; bus.req_data = '0; bus.flush = 1'b0;
`ifdef REG_ARB_LOCK_EN
        bus.lock = '0;
`endif
        // Reset hold with all requesting
        @(negedge clk);
        bus.req = 4'hF; bus.req_data = 32'h44332211;
        tick(); expect_out("rst0", 4'b0000, 0, 0, 8'h00, 0);
        tick(); expect_out("rst1", 4'b0000, 0, 0, 8'h00, 0);
        @(negedge clk); clear = 1'b0;
        tick(); expect_out("cont0", 4'b0001, 1, 0, 8'h11, 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); bus.req = bus.req & ~bus.ack;
            tick(); expect_out("cont", 4'(1 << k), 1, 0, 8'(8'h11 * (k + 1)), k);
        end
        @(negedge clk); bus.req = '0;
        tick(); expect_out("idle_hold", 4'b0000, 0, 0, 8'h44, 3);

        // Wrap
        @(negedge clk); bus.req = 4'b0100; bus.req_data[2*N +: N] = 8'h3C;
        tick(); expect_out("wrap_g2", 4'b0100, 1, 0, 8'h3C, 2);
        @(negedge clk); bus.req = 4'b0101; bus.req_data[0 +: N] = 8'h5A;
        tick(); expect_out("wrap_g0", 4'b0001, 1, 0, 8'h5A, 0);
        @(negedge clk); bus.req = 4'b0100;
        tick(); expect_out("wrap_g2b", 4'b0100, 1, 0, 8'h3C, 2);

        // Clear beats load within one requester
        @(negedge clk); bus.req = 4'b0010; bus.clr_req = 4'b0010; bus.req_data[N +: N] = 8'hAA;
        tick(); expect_out("clrprec", 4'b0010, 0, 1, 8'h00, 1);
        @(negedge clk); bus.clr_req = '0;
        tick(); expect_out("clrmask", 4'b0000, 0, 0, 8'h00, 1);
        tick(); expect_out("clrload", 4'b0010, 1, 0, 8'hAA, 1);

        // Flush first, request after
        @(negedge clk); bus.req = '0;
        tick(); expect_out("pre_flush", 4'b0000, 0, 0, 8'hAA, 1);
        @(negedge clk); bus.req = 4'b0010; bus.req_data[N +: N] = 8'h77; bus.flush = 1'b1;
        tick(); expect_out("flush", 4'b0000, 0, 1, 8'h00, 1);
        @(negedge clk); bus.flush = 1'b0;
        tick(); expect_out("post_flush", 4'b0010, 1, 0, 8'h77, 1);

        // Reset during an ack cycle, pointer returns to 0
        @(negedge clk); clear = 1'b1; bus.req = 4'hF; bus.req_data = 32'h44332211;
        tick(); expect_out("midrst", 4'b0000, 0, 0, 8'h00, 0);
        @(negedge clk); clear = 1'b0;
        tick(); expect_out("ptr0", 4'b0001, 1, 0, 8'h11, 0);

        // Fairness with all four continuously active
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("fair_ack", 32'(bus.ack), 32'(1 << (k % 4)));
        end

        // Randomized traffic
        @(negedge clk); bus.req = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            clear = ($urandom_range(99) == 0);
            bus.flush = ($urandom_range(15) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i]) begin
                    if (bus.clr_req[i]) bus.clr_req[i] = 1'b0;
                    else if ($urandom_range(1) == 1) bus.req[i] = 1'b0;
                end
                if (!bus.req[i] && !bus.clr_req[i]) begin
                    if ($urandom_range(2) == 0) begin
                        bus.req[i] = 1'b1;
                        bus.req_data[i*N +: N] = N'($urandom);
                    end
                    if ($urandom_range(7) == 0) bus.clr_req[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        clear = 1'b0; bus.flush = 1'b0; bus.req = '0; bus.clr_req = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Round-robin arbiter that shares one N-bit load/clear register among NREQ requesters.
- Drives the register's load, clear and data-in pins, one transaction per cycle.
- Returns a one-cycle ack to the requester that was served.
- Sits between requester logic and a single shared storage register, so no two sources ever drive load in the same cycle.

Parameters:
N, 8, data width of the shared register
NREQ, 4, number of requesters (2..16)
PW, $clog2(NREQ), width of the grant index and pointer

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous active-high reset
req  input  NREQ  per-requester load request, level, held until acked
clr_req  input  NREQ  per-requester clear request, level, held until acked
req_data  input  NREQ*N  per-requester load data, requester i at bits [i*N +: N]
flush  input  1  global clear command; wins over all requesters
ack  output  NREQ  one-hot, one-cycle pulse to the served requester
reg_load  output  1  load strobe to shared register
reg_clear  output  1  clear strobe to shared register
reg_in  output  N  data to shared register
last_grant  output  PW  index of most recently served requester
busy  output  1  high when reg_load or reg_clear is high

Behaviour:
- Reset, when clear=1 at a clk edge:
  - ack=0, reg_load=0, reg_clear=0, reg_in=0, last_grant=0, busy=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - Reset has priority over every other input, including mid-transaction.
- Outputs are all registered. A decision taken in cycle t appears on the outputs in cycle t+1. The shared register captures at the end of t+1.
- Eligibility: active[i] = (req[i] | clr_req[i]) & ~ack[i].
  - The requester currently seeing ack is masked, so it cannot be double-granted in the cycle it drops its request.
- Selection: the first active index found searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1 (modulo NREQ).
- States:
  - IDLE: no outputs asserted.
  - SERVE: one ack plus one strobe asserted.
  - FLUSH: reg_clear only, no ack.
  - The next state is chosen every cycle from the current inputs. There are no multi-cycle holds.
- Transitions, evaluated each cycle:
  - flush=1 → FLUSH: reg_clear=1, reg_load=0, reg_in=0, ack=0; ptr and last_grant unchanged; pending requests wait.
  - else any active → SERVE, with g = the selected index:
    - ack[g]=1, last_grant=g, ptr=(g+1) mod NREQ.
    - If clr_req[g]=1: reg_clear=1, reg_load=0, reg_in=0. Clear wins over load within one requester; req[g] stays pending.
    - Else: reg_load=1, reg_clear=0, reg_in=req_data[g].
  - else → IDLE: strobes and ack=0; reg_in holds its previous value.
- Simultaneous events:
  - flush with requests: flush served first, requests follow in later cycles.
  - Requests arriving during an ack cycle: considered in that same cycle.
- At most one of reg_load, reg_clear is high in any cycle. At most one ack bit is high.
- Fairness: with all NREQ requesters continuously active, each is served exactly once in any NREQ consecutive SERVE cycles.
- Pointer wraps from NREQ-1 to 0. NREQ values that are not a power of two must wrap correctly; there is no out-of-range index.

Optional Feature:
- Macro: REG_ARB_LOCK_EN.
- When defined:
  - Adds input port lock, width NREQ.
  - At a SERVE to g with lock[g]=1, ptr is set to g instead of g+1, so g keeps top priority for back-to-back transactions.
  - The ack-cycle mask still applies, so g's next transaction can be served at the earliest two cycles after its previous ack.
  - Lock is released when g is served with lock[g]=0, or when g has no active request while others do.
  - flush and reset override lock; reset forces ptr=0.
- When undefined: no lock port; pure round-robin as above.

Test Plan:
- Reset hold: clear=1 for 2 cycles with req=4'b1111 → all outputs 0 during and one cycle after; first ack after release is ack=4'b0001.
- Full contention: req=4'b1111 with data 0x11,0x22,0x33,0x44, each requester drops req the cycle after its ack → ack 0001,0010,0100,1000 on consecutive cycles; reg_load=1 with reg_in 0x11,0x22,0x33,0x44; last_grant 0..3.
- Wrap: after a grant to requester 2 (ptr=3), assert req=4'b0101 → ack=4'b0001, reg_in=req_data[0]; next ack=4'b0100.
- Clear precedence: requester 1 asserts req=1, clr_req=1, data 0xAA → reg_clear=1, reg_load=0, reg_in=0x00, ack=4'b0010.
- Flush vs. mid-operation reset:
  - flush=1 for 1 cycle with req=4'b0010 → reg_clear=1, ack=0; the following cycle reg_load=1, reg_in=req_data[1], ack=4'b0010.
  - clear=1 asserted during an ack cycle → next cycle all outputs 0, ptr=0.
- With REG_ARB_LOCK_EN: lock[2]=1, requester 2 re-requests immediately, req[3] held → grants alternate 2,3?,2 … must show requester 2 served every 2 cycles while lock[2]=1. Requester 3 is served in the gap cycles only. After lock[2]=0, requester 3 is served next.
